// File: rtl/adxl345_pkg.sv
// ADXL345 register map, command-byte layout and sequencer state encoding shared by
// the sample sequencer and its sub-blocks.
package adxl345_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;

  localparam int RW_BIT = 7;
  localparam int MB_BIT = 6;

  localparam logic [7:0] DEVID_VAL  = 8'hE5;
  localparam logic [3:0] XYZ_NBYTES = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ID     = 3'd1,
    ST_WR_FMT    = 3'd2,
    ST_WR_PWR    = 3'd3,
    ST_WAIT_TICK = 3'd4,
    ST_RD_XYZ    = 3'd5,
    ST_ERR       = 3'd6
  } seq_state_e;

  // First SPI byte: read flag, multi-byte flag, register address.
  function automatic logic [7:0] mk_cmd(input logic rd, input logic mb, input logic [5:0] addr);
    logic [7:0] c;
    c         = {2'b00, addr};
    c[RW_BIT] = rd;
    c[MB_BIT] = mb;
    return c;
  endfunction

endpackage

// File: rtl/adxl345_tick_gen.sv
// Sample-period divider: counts SAMPLE_DIV clocks while enabled and emits a
// single-cycle tick each time the count wraps.
module adxl345_tick_gen
  import adxl345_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Counter restarts from zero whenever sampling is switched off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/adxl345_sample_sequencer.sv
// ADXL345 command sequencer: checks DEVID, programs DATA_FORMAT and POWER_CTL, then
// issues a 6-byte XYZ burst read on every sample tick and publishes the result.
module adxl345_sample_sequencer
  import adxl345_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter logic [7:0]  FMT_VAL    = 8'h0B,
  parameter logic [7:0]  PWR_VAL    = 8'h08,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               spi_start,
  output logic [7:0]         spi_cmd,
  output logic [7:0]         spi_wdata,
  output logic [3:0]         spi_nbytes,
  input  logic               spi_busy,
  input  logic               spi_rx_valid,
  input  logic [7:0]         spi_rx_data,
  input  logic               spi_done,
  output logic signed [15:0] x_data,
  output logic signed [15:0] y_data,
  output logic signed [15:0] z_data,
  output logic               sample_valid,
  output logic               ready,
  output logic               id_err,
  output logic               timeout_err,
  output logic               overrun
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_e      state_q;
  logic            issued_q;
  logic            pending_q;
  logic [WD_W-1:0] wd_q;
  logic [2:0]      idx_q;
  logic [2:0]      idx_d;
  logic [7:0]      shadow_q [6];
  logic [7:0]      shadow_d [6];

  logic       tick_s;
  logic       tick_live_s;
  logic       cmd_state_s;
  logic       launch_s;
  logic       consumed_s;
  logic       xyz_full_s;
  logic       id_ok_s;
  logic [7:0] cmd_sel_s;
  logic [7:0] wdata_sel_s;
  logic [3:0] nbytes_sel_s;

  adxl345_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ready),
    .tick_o (tick_s)
  );

  // Command image presented by each transaction state.
  always_comb begin
    cmd_state_s  = 1'b0;
    cmd_sel_s    = 8'h00;
    wdata_sel_s  = 8'h00;
    nbytes_sel_s = 4'd0;
    case (state_q)
      ST_RD_ID: begin
        cmd_state_s  = 1'b1;
        cmd_sel_s    = mk_cmd(1'b1, 1'b0, ADDR_DEVID);
        nbytes_sel_s = 4'd1;
      end
      ST_WR_FMT: begin
        cmd_state_s = 1'b1;
        cmd_sel_s   = mk_cmd(1'b0, 1'b0, ADDR_DATA_FORMAT);
        wdata_sel_s = FMT_VAL;
      end
      ST_WR_PWR: begin
        cmd_state_s = 1'b1;
        cmd_sel_s   = mk_cmd(1'b0, 1'b0, ADDR_POWER_CTL);
        wdata_sel_s = PWR_VAL;
      end
      ST_RD_XYZ: begin
        cmd_state_s  = 1'b1;
        cmd_sel_s    = mk_cmd(1'b1, 1'b1, ADDR_DATAX0);
        nbytes_sel_s = XYZ_NBYTES;
      end
      default: begin
        cmd_state_s = 1'b0;
      end
    endcase
  end

  assign tick_live_s = tick_s & ready;
  assign launch_s    = cmd_state_s & ~issued_q & enable & ~spi_busy;
  assign consumed_s  = (state_q == ST_WAIT_TICK) & enable & pending_q;

  // Received bytes land in the shadow at the running index; extras past index 5 are dropped.
  always_comb begin
    idx_d = idx_q;
    for (int i = 0; i < 6; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (cmd_state_s && issued_q && spi_rx_valid && (idx_q < 3'd6)) begin
      shadow_d[idx_q] = spi_rx_data;
      idx_d           = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // Byte done together with spi_done still counts, hence the _d view here.
  assign xyz_full_s = (idx_d == 3'd6);
  assign id_ok_s    = (idx_d != 3'd0) && (shadow_d[0] == DEVID_VAL);

  // Byte index restarts at each launch; shadow bytes persist until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 3'd0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else if (launch_s) begin
      idx_q <= 3'd0;
    end else begin
      idx_q <= idx_d;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Sequencer FSM with registered command outputs, status flags, watchdog and tick bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issued_q     <= 1'b0;
      pending_q    <= 1'b0;
      wd_q         <= '0;
      spi_start    <= 1'b0;
      spi_cmd      <= 8'h00;
      spi_wdata    <= 8'h00;
      spi_nbytes   <= 4'd0;
      x_data       <= 16'sh0000;
      y_data       <= 16'sh0000;
      z_data       <= 16'sh0000;
      sample_valid <= 1'b0;
      ready        <= 1'b0;
      id_err       <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      spi_start    <= 1'b0;
      sample_valid <= 1'b0;
      pending_q    <= pending_q | tick_live_s;
      if (tick_live_s && pending_q && !consumed_s) begin
        overrun <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (enable && !spi_busy) begin
            state_q     <= ST_RD_ID;
            issued_q    <= 1'b0;
            id_err      <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
          end
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            state_q   <= ST_IDLE;
            ready     <= 1'b0;
            pending_q <= 1'b0;
          end else if (pending_q) begin
            state_q   <= ST_RD_XYZ;
            issued_q  <= 1'b0;
            pending_q <= tick_live_s;
          end
        end
        ST_ERR: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_ID, ST_WR_FMT, ST_WR_PWR, ST_RD_XYZ: begin
          if (!issued_q) begin
            if (!enable) begin
              state_q   <= ST_IDLE;
              ready     <= 1'b0;
              pending_q <= 1'b0;
            end else if (launch_s) begin
              spi_start  <= 1'b1;
              spi_cmd    <= cmd_sel_s;
              spi_wdata  <= wdata_sel_s;
              spi_nbytes <= nbytes_sel_s;
              issued_q   <= 1'b1;
              wd_q       <= '0;
            end
          end else if (spi_done) begin
            issued_q <= 1'b0;
            if ((state_q == ST_RD_XYZ) && xyz_full_s) begin
              x_data       <= {shadow_d[1], shadow_d[0]};
              y_data       <= {shadow_d[3], shadow_d[2]};
              z_data       <= {shadow_d[5], shadow_d[4]};
              sample_valid <= 1'b1;
            end
            // Disable takes effect only once the bus transaction has closed.
            if (!enable) begin
              state_q   <= ST_IDLE;
              ready     <= 1'b0;
              pending_q <= 1'b0;
            end else begin
              case (state_q)
                ST_RD_ID: begin
                  if (id_ok_s) begin
                    state_q <= ST_WR_FMT;
                  end else begin
                    id_err  <= 1'b1;
                    state_q <= ST_ERR;
                  end
                end
                ST_WR_FMT: state_q <= ST_WR_PWR;
                ST_WR_PWR: begin
                  state_q <= ST_WAIT_TICK;
                  ready   <= 1'b1;
                end
                default: state_q <= ST_WAIT_TICK;
              endcase
            end
          end else if (wd_q == WD_LAST) begin
            timeout_err <= 1'b1;
            state_q     <= ST_ERR;
            ready       <= 1'b0;
            pending_q   <= 1'b0;
            issued_q    <= 1'b0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
